bit_serial_alu: RTL and testbench

- Multi-cycle bit-serial ALU engine. It drives a single-bit ALU datapath slice one bit per cycle, LSB first, and ripples the carry through a register.
- It produces a WIDTH-bit result plus negative/zero/overflow/carry_out flags.
- Sits beside the parallel ALU as the area-reduced execute option for the pipelined CPU.
- Uses the same 3-bit cntrl operation encoding as the ALU.

---
 rtl/bit_serial_alu_pkg.sv | 14 +
 rtl/bit_serial_alu_if.sv | 18 +
 rtl/bit_serial_alu_slice.sv | 23 ++
 rtl/bit_serial_alu.sv | 111 +++++++++++
 tb/tb_bit_serial_alu.sv | 129 ++++++++++++
 5 files changed

// File: rtl/bit_serial_alu_pkg.sv
// alu_pkg: shared cntrl encodings and serial engine state type for the ALU family
package alu_pkg;
    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_RSVD   = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;
    typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;
    function automatic logic is_arith(input logic [2:0] op);
        return op == ALU_ADD || op == ALU_SUB;
    endfunction
endpackage

// File: rtl/bit_serial_alu_if.sv
// bit_serial_alu_if: request/response bundle between a requester and the serial ALU
interface bit_serial_alu_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    modport master (output in_valid, cntrl, A, B,
                    input in_ready, out_valid, result, negative, zero, overflow, carry_out);
    modport slave (input in_valid, cntrl, A, B,
                   output in_ready, out_valid, result, negative, zero, overflow, carry_out);
endinterface

// File: rtl/bit_serial_alu_slice.sv
// serial_alu_slice: one-bit ALU datapath (b-invert, full adder, logic ops, select by cntrl)
module serial_alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       y,
    output logic       cout
);
    logic bx, sum;
    always_comb begin
        bx   = (op == ALU_SUB) ? ~b : b;
        sum  = a ^ bx ^ cin;
        cout = (a & bx) | (cin & (a ^ bx));
        y    = (op == ALU_PASS_B) ? b :
               is_arith(op)       ? sum :
               (op == ALU_AND)    ? a & b :
               (op == ALU_OR)     ? a | b :
               (op == ALU_XOR)    ? a ^ b : 1'b0;
    end
endmodule

// File: rtl/bit_serial_alu.sv
// bit_serial_alu: multi-cycle LSB-first serial ALU with NZVC flags.
// BIT_SERIAL_ALU_LOGIC_BYPASS_EN: non-arithmetic ops complete in parallel at accept.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic               clk,
    input logic               reset_n,
    bit_serial_alu_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    serial_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d, neg_q, neg_d, zero_q, zero_d, ov_q, ov_d, co_q, co_d;
    logic             y, cout, fin;
    serial_alu_slice u_slice (
        .a(a_sh_q[0]), .b(b_sh_q[0]), .cin(carry_q), .op(op_q), .y(y), .cout(cout)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        ov_d     = ov_q;
        co_d     = co_q;
        fin      = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_sh_d  = bus.A;
                b_sh_d  = bus.B;
                op_d    = bus.cntrl;
                cnt_d   = '0;
                carry_d = bus.cntrl == ALU_SUB;
                state_d = RUN;
`ifdef BIT_SERIAL_ALU_LOGIC_BYPASS_EN
                if (!is_arith(bus.cntrl)) begin
                    result_d = (bus.cntrl == ALU_PASS_B) ? bus.B :
                               (bus.cntrl == ALU_AND)    ? bus.A & bus.B :
                               (bus.cntrl == ALU_OR)     ? bus.A | bus.B :
                               (bus.cntrl == ALU_XOR)    ? bus.A ^ bus.B : '0;
                    ov_d     = 1'b0;
                    co_d     = 1'b0;
                    fin      = 1'b1;
                    state_d  = DONE;
                end
`endif
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {y, res_sh_q[WIDTH-1:1]};
                carry_d  = cout;
                cnt_d    = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB, so V = cin_msb ^ cout
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = res_sh_d;
                    co_d     = is_arith(op_q) & cout;
                    ov_d     = is_arith(op_q) & (carry_q ^ cout);
                    fin      = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        neg_d  = fin ? result_d[WIDTH-1] : neg_q;
        zero_d = fin ? (result_d == '0) : zero_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ov_q     <= 1'b0;
            co_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ov_q     <= ov_d;
            co_q     <= co_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ov_q;
    assign bus.carry_out = co_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: directed vectors with a scoreboard queue drained by an output monitor
module tb_bit_serial_alu;
    import alu_pkg::*;
    localparam int W = 8;
    typedef struct {
        string      name;
        logic [11:0] flags;
        int         due;
    } exp_t;
    logic clk, reset_n;
    int   cyc, checks, errors;
    exp_t sb[$];
    bit_serial_alu_if #(.WIDTH(W)) bus ();
    bit_serial_alu #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endfunction
    function automatic int lat(input logic [2:0] op);
`ifdef BIT_SERIAL_ALU_LOGIC_BYPASS_EN
        if (!is_arith(op)) return 1;
`endif
        return W + 1;
    endfunction
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_rnzvc"},
                    64'({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out}), 64'(e.flags));
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
    end
    task automatic issue(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic n, input logic z, input logic v, input logic c,
                         input bit push);
        int k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk({name, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
        bus.cntrl = op;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) sb.push_back('{name: name, flags: {r, n, z, v, c}, due: cyc + lat(op) - 1});
    endtask
    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask
    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.cntrl = ALU_PASS_B;
        bus.A = '0;
        bus.B = '0;
        #2;
        chk("reset_outputs", 64'({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out}), 64'd0);
        chk("reset_handshake", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue("add_7f_01", ALU_ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 1, 0, 1);
        issue("sub_05_05", ALU_SUB, 8'h05, 8'h05, 8'h00, 0, 1, 0, 1, 1);
        issue("sub_00_01", ALU_SUB, 8'h00, 8'h01, 8'hFF, 1, 0, 0, 0, 1);
        issue("xor_aa_ff", ALU_XOR, 8'hAA, 8'hFF, 8'h55, 0, 0, 0, 0, 1);
        issue("rsvd_001", ALU_RSVD, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 0, 1);
        issue("pass_b_3c", ALU_PASS_B, 8'h00, 8'h3C, 8'h3C, 0, 0, 0, 0, 1);
        issue("and_f0_3c", ALU_AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1);
        issue("or_81_02", ALU_OR, 8'h81, 8'h02, 8'h83, 1, 0, 0, 0, 1);
        issue("add_ff_01", ALU_ADD, 8'hFF, 8'h01, 8'h00, 0, 1, 0, 1, 1);
        issue("sub_80_01", ALU_SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 1, 1);
        issue("rsvd_111", 3'b111, 8'h12, 8'h34, 8'h00, 0, 1, 0, 0, 1);
        issue("xor_0f_ff", ALU_XOR, 8'h0F, 8'hFF, 8'hF0, 1, 0, 0, 0, 1);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_result", 64'({bus.result, bus.negative, bus.zero}), 64'({8'hF0, 1'b1, 1'b0}));
        issue("busy_add_40_40", ALU_ADD, 8'h40, 8'h40, 8'h80, 1, 0, 1, 0, 1);
        @(negedge clk);
        bus.cntrl = ALU_ADD;
        bus.A = 8'h01;
        bus.B = 8'h01;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        issue("aborted_add", ALU_ADD, 8'h11, 8'h22, 8'h00, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midop_reset_outputs",
            64'({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out, bus.out_valid}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_ready", 64'(bus.in_ready), 64'd1);
        issue("sub_10_01", ALU_SUB, 8'h10, 8'h01, 8'h0F, 0, 0, 0, 1, 1);
        drain();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
